inv_key_sched: RTL and testbench

Iterative AES-128 key scheduler with round-key buffer for the decryption datapath. It accepts a 128-bit cipher key and expands one round key per clock using the existing `round_key` expansion step, with its four `sbox` instances. It stores all 11 round keys and then streams them to the round pipeline over a valid/ready handshake. Order is reverse (round 10 down to 0) for decryption, or forward (round 0 up to 10) for encryption. It replaces the fully unrolled combinational schedule where area matters.

---
 rtl/inv_key_sched_if.sv | 24 ++
 rtl/inv_key_sched.sv | 171 +++++++++++++++++
 tb/tb_inv_key_sched.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_key_sched_if.sv
// Key-load and round-key stream bundle for inv_key_sched.
// The master side supplies keys and consumes round keys; the slave side is the scheduler.
interface inv_key_sched_if;
  logic [0:127] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         dec;
  logic         replay;
  logic [0:127] rk_data;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  modport master (
    output key_in, key_valid, dec, replay, rk_ready,
    input  key_ready, rk_data, rk_round, rk_valid, busy
  );

  modport slave (
    input  key_in, key_valid, dec, replay, rk_ready,
    output key_ready, rk_data, rk_round, rk_valid, busy
  );
endinterface

// File: rtl/inv_key_sched.sv
// Iterative AES-128 key scheduler: expands one round key per clock into an 11-slot buffer,
// then streams it in reverse (decrypt) or forward (encrypt) order. KEYSCHED_REPLAY_EN adds replay.
module inv_key_sched (
  input  logic            clk,
  input  logic            rst_n,
  inv_key_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_e;

  localparam logic [3:0] LAST_STEP  = 4'd9;
  localparam logic [3:0] LAST_ROUND = 4'd10;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine transform.
  function automatic logic [7:0] sub_byte(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] s);
    case (s)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [0:127] round_key(input logic [0:127] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[0:31];
    w1 = k[32:63];
    w2 = k[64:95];
    w3 = k[96:127];
    t  = {sub_byte(w3[23:16]), sub_byte(w3[15:8]), sub_byte(w3[7:0]), sub_byte(w3[31:24])}
         ^ {rc, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   step_q, step_d;
  logic [3:0]   ptr_q, ptr_d;
  logic         dec_q, dec_d;
  logic [0:127] slot_q [0:10];
  logic         load_key;
  logic         expand_we;
  logic         last_key;
  logic [0:127] expand_rk;
  logic [3:0]   start_ptr;

  assign expand_rk = round_key(slot_q[step_q], rcon(step_q));
  assign last_key  = dec_q ? (ptr_q == 4'd0) : (ptr_q == LAST_ROUND);
  assign start_ptr = dec_q ? LAST_ROUND : 4'd0;

`ifdef KEYSCHED_REPLAY_EN
  logic have_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         have_q <= 1'b0;
    else if (state_q == EXPAND && step_q == LAST_STEP)  have_q <= 1'b1;
  end
`else
  logic unused_replay;
  assign unused_replay = bus.replay;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    step_d    = step_q;
    ptr_d     = ptr_q;
    dec_d     = dec_q;
    load_key  = 1'b0;
    expand_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          load_key = 1'b1;
          dec_d    = bus.dec;
          step_d   = 4'd0;
          state_d  = EXPAND;
        end
`ifdef KEYSCHED_REPLAY_EN
        else if (bus.replay && have_q) begin
          ptr_d   = start_ptr;
          state_d = STREAM;
        end
`endif
      end
      EXPAND: begin
        expand_we = 1'b1;
        if (step_q == LAST_STEP) begin
          step_d  = 4'd0;
          ptr_d   = start_ptr;
          state_d = STREAM;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      STREAM: begin
        if (bus.rk_ready) begin
          if (last_key) state_d = IDLE;
          else          ptr_d   = dec_q ? ptr_q - 4'd1 : ptr_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 4'd0;
      ptr_q   <= 4'd0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ptr_q   <= ptr_d;
      dec_q   <= dec_d;
    end
  end

  // NOTE: the slot buffer is reset on purpose; a reset must wipe any stored key material.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) slot_q[i] <= '0;
    end else if (load_key) begin
      slot_q[0] <= bus.key_in;
    end else if (expand_we) begin
      slot_q[step_q + 4'd1] <= expand_rk;
    end
  end

  assign bus.key_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rk_valid  = (state_q == STREAM);
  assign bus.rk_data   = (state_q == STREAM) ? slot_q[ptr_q] : '0;
  assign bus.rk_round  = (state_q == STREAM) ? ptr_q : 4'd0;
endmodule

// File: tb/tb_inv_key_sched.sv
// Scoreboard bench for inv_key_sched against the FIPS-197 AES-128 expansion of 2b7e1516...
// Replay checks follow KEYSCHED_REPLAY_EN.
module tb_inv_key_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_key_sched_if bus ();
  inv_key_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [3:0]   round;
    logic [0:127] data;
  } exp_t;

  localparam logic [0:127] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;

  task automatic push_schedule(input logic d);
    for (int i = 0; i < 11; i++) begin
      int r;
      r = d ? 10 - i : i;
      sb.push_back('{round: 4'(r), data: FIPS_RK[r]});
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first EXPAND cycle.
  task automatic load_key(input logic [0:127] k, input logic d);
    bus.key_in    = k;
    bus.dec       = d;
    bus.key_valid = 1'b1;
    tests++;
    if (bus.key_ready !== 1'b1) begin
      fails++; $display("FAIL load_ready: key_ready=%b required 1", bus.key_ready);
    end
    @(negedge clk);
    bus.key_valid = 1'b0;
    tests++;
    if ({bus.key_ready, bus.busy, bus.rk_valid} !== 3'b010) begin
      fails++; $display("FAIL load_expand: ready/busy/valid=%b required 010",
                        {bus.key_ready, bus.busy, bus.rk_valid});
    end
    push_schedule(d);
  endtask

  task automatic wait_valid(input int start, input int exp_lat);
    int lat;
    lat = start;
    while (!bus.rk_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (lat !== exp_lat) begin
      fails++; $display("FAIL latency: rk_valid after %0d cycles required %0d", lat, exp_lat);
    end
  endtask

  task automatic drain(input bit rand_ready, input bit inject, output int cycles);
    exp_t         e;
    logic         r;
    bit           holding;
    logic [0:127] hold_d;
    logic [3:0]   hold_r;
    holding = 1'b0;
    hold_d  = '0;
    hold_r  = '0;
    cycles  = 0;
    while (sb.size() > 0 && cycles < 400) begin
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rk_ready = r;
      if (inject) begin
        bus.key_in    = OTHER_KEY;
        bus.key_valid = cycles[0];
        tests++;
        if (bus.key_ready !== 1'b0) begin
          fails++; $display("FAIL stream_key_ready: key_ready=%b required 0", bus.key_ready);
        end
      end
      if (holding) begin
        tests++;
        if ({bus.rk_round, bus.rk_data} !== {hold_r, hold_d}) begin
          fails++; $display("FAIL hold: round %0d data %h required round %0d data %h",
                            bus.rk_round, bus.rk_data, hold_r, hold_d);
        end
      end
      if (bus.rk_valid && r) begin
        e = sb.pop_front();
        tests++;
        if (bus.rk_round !== e.round || bus.rk_data !== e.data) begin
          fails++; $display("FAIL stream_key: round %0d data %h required round %0d data %h",
                            bus.rk_round, bus.rk_data, e.round, e.data);
        end
      end
      holding = bus.rk_valid && !r;
      hold_d  = bus.rk_data;
      hold_r  = bus.rk_round;
      cycles++;
      @(negedge clk);
    end
    bus.key_valid = 1'b0;
    bus.rk_ready  = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL drain_timeout: %0d keys outstanding required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic check_idle_after(input string name);
    tests++;
    if ({bus.key_ready, bus.rk_valid, bus.busy} !== 3'b100) begin
      fails++; $display("FAIL %s: ready/valid/busy=%b required 100", name,
                        {bus.key_ready, bus.rk_valid, bus.busy});
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if ({bus.key_ready, bus.rk_valid, bus.busy} !== 3'b100 || bus.rk_data !== '0 ||
        bus.rk_round !== 4'd0) begin
      fails++; $display("FAIL %s: ready/valid/busy=%b data %h round %0d required 100, 0, 0",
                        name, {bus.key_ready, bus.rk_valid, bus.busy}, bus.rk_data, bus.rk_round);
    end
  endtask

  task automatic test_reset();
    bus.key_in = '0; bus.key_valid = 1'b0; bus.dec = 1'b0; bus.replay = 1'b0; bus.rk_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_release");
  endtask

  task automatic test_replay_before_expand();
    bus.replay = 1'b1;
    @(negedge clk);
    bus.replay = 1'b0;
    check_idle_after("replay_before_expand");
    @(negedge clk);
  endtask

  task automatic test_ordered(input logic d, input bit rand_ready, input string name);
    int cyc;
    load_key(FIPS_KEY, d);
    wait_valid(1, 11);
    drain(rand_ready, 1'b0, cyc);
    if (!rand_ready) begin
      tests++;
      if (cyc !== 11) begin
        fails++; $display("FAIL %s_throughput: %0d cycles required 11", name, cyc);
      end
    end
    check_idle_after(name);
  endtask

  task automatic test_ignored_load();
    int cyc;
    load_key(FIPS_KEY, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.key_in    = OTHER_KEY;
      bus.key_valid = 1'b1;
      tests++;
      if (bus.key_ready !== 1'b0) begin
        fails++; $display("FAIL expand_key_ready: key_ready=%b required 0", bus.key_ready);
      end
      @(negedge clk);
    end
    bus.key_valid = 1'b0;
    wait_valid(5, 11);
    drain(1'b1, 1'b1, cyc);
    check_idle_after("ignored_load_end");
  endtask

  task automatic test_reset_midop();
    int cyc;
    int n;
    load_key(FIPS_KEY, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_expand");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_key(FIPS_KEY, 1'b1);
    wait_valid(1, 11);
    n = 0;
    while (!(bus.rk_valid && bus.rk_round == 4'd4) && n < 20) begin
      bus.rk_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== 6) begin
      fails++; $display("FAIL reach_round4: %0d handshakes required 6", n);
    end
    rst_n = 1'b0;
    bus.rk_ready = 1'b0;
    #1;
    check_reset_outputs("reset_mid_stream");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_key(FIPS_KEY, 1'b0);
    wait_valid(1, 11);
    drain(1'b0, 1'b0, cyc);
    check_idle_after("reload_after_reset");
  endtask

  task automatic test_replay();
    int cyc;
    test_ordered(1'b1, 1'b0, "pre_replay");
`ifdef KEYSCHED_REPLAY_EN
    bus.replay = 1'b1;
    @(negedge clk);
    bus.replay = 1'b0;
    tests++;
    if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd10) begin
      fails++; $display("FAIL replay_start: valid=%b round %0d required 1, 10",
                        bus.rk_valid, bus.rk_round);
    end
    push_schedule(1'b1);
    drain(1'b0, 1'b0, cyc);
    check_idle_after("replay_end");
    bus.replay = 1'b1;
    load_key(FIPS_KEY, 1'b0);
    bus.replay = 1'b0;
    wait_valid(1, 11);
    drain(1'b0, 1'b0, cyc);
    check_idle_after("key_beats_replay");
`else
    bus.replay = 1'b1;
    @(negedge clk);
    bus.replay = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle_after("replay_ignored");
      @(negedge clk);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_replay_before_expand();
    test_ordered(1'b1, 1'b0, "fips_decrypt");
    test_ordered(1'b0, 1'b0, "forward_order");
    test_ordered(1'b1, 1'b1, "backpressure_dec");
    test_ordered(1'b0, 1'b1, "backpressure_fwd");
    test_ignored_load();
    test_reset_midop();
    test_replay();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
